// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush and load-use bubble.
// Control outputs are combinational from state and inputs; wait counter, timeout flag and stall counter are registered.
module pipeline_stall_ctrl #(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             ex_mem_memread,
  input  logic             ex_mem_memwrite,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          load_use;
  logic          access_pending;
  logic          freeze;
  logic          run_flush;
  logic          run_bubble;

  assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign access_pending = ex_mem_memread | ex_mem_memwrite;

  // Branch outranks load-use once the memory side is not freezing the pipe.
  assign run_flush  = branch_taken;
  assign run_bubble = !branch_taken && load_use;

  always_comb begin
    state_nxt    = state;
    freeze       = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    dmem_req     = 1'b0;

    case (state)
      RUN: begin
        dmem_req = access_pending;
        if (access_pending && !dmem_ready) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (run_flush) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt   = FLUSH;
        end else if (run_bubble) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end

      MEM_WAIT: begin
        dmem_req = access_pending;
        if (!dmem_ready) begin
          freeze = 1'b1;
        end else begin
          // Release cycle: the held branch or hazard is acted on now, then back to RUN.
          state_nxt = RUN;
          if (run_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (run_bubble) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      end

      FLUSH: begin
        state_nxt = RUN;
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_mem_hold = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts consecutive frozen cycles; the first frozen cycle happens in RUN and loads 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (freeze) begin
      if (state == RUN) begin
        wait_cnt <= WW'(1);
      end else if (wait_cnt != WAIT_LIM) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_timeout <= 1'b0;
    end else if ((state == MEM_WAIT) && !dmem_ready && (wait_cnt == WAIT_LIM)) begin
      mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed hazard scenarios with literal expectations,
// then randomized traffic checked every cycle against an event-level model of the pipe.
module tb_pipeline_stall_ctrl;

  localparam int WAIT_MAX = 8;
  localparam int CW       = 4;

  logic          clk;
  logic          reset;
  logic          id_ex_memread;
  logic [4:0]    id_ex_rt;
  logic [4:0]    if_id_rs;
  logic [4:0]    if_id_rt;
  logic          ex_mem_memread;
  logic          ex_mem_memwrite;
  logic          dmem_ready;
  logic          branch_taken;
  logic          pc_write;
  logic          if_id_write;
  logic          id_ex_bubble;
  logic          ex_mem_hold;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          dmem_req;
  logic          mem_timeout;
  logic [CW-1:0] stall_count;

  pipeline_stall_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_hold(ex_mem_hold), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .dmem_req(dmem_req), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: how long the memory side has been frozen, whether the previous cycle
  // launched a branch flush from normal flow, sticky timeout, total stalled cycles.
  bit m_prev_freeze;
  int m_freeze_len;
  bit m_skip;
  bit m_timeout;
  int m_stalls;

  string onames [8] = '{"pc_write", "if_id_write", "id_ex_bubble", "ex_mem_hold",
                        "if_id_flush", "id_ex_flush", "dmem_req", "mem_timeout"};

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_freeze = 1'b0;
    m_freeze_len  = 0;
    m_skip        = 1'b0;
    m_timeout     = 1'b0;
    m_stalls      = 0;
  endtask

  // One clock cycle: drive at negedge, compare just after, advance the model for the coming edge.
  task automatic step(input logic r, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] rt2, input logic emr, input logic emw,
                      input logic rdy, input logic br);
    logic [7:0]    obs;
    logic [7:0]    exp;
    logic [CW-1:0] exp_cnt;
    bit lu, ap, frz, fl, bub;
    @(negedge clk);
    reset = r; id_ex_memread = mr; id_ex_rt = rt; if_id_rs = rs; if_id_rt = rt2;
    ex_mem_memread = emr; ex_mem_memwrite = emw; dmem_ready = rdy; branch_taken = br;
    #1;
    if (r) model_reset();
    lu  = mr && (rt != 5'd0) && (rt == rs || rt == rt2);
    ap  = emr || emw;
    frz = !m_skip && !rdy && (m_prev_freeze || ap);
    fl  = !m_skip && !frz && br;
    bub = !m_skip && !frz && !br && lu;
    exp = {!(frz || bub), !(frz || bub), bub, frz, fl, fl, !m_skip && ap, m_timeout};
    obs = {pc_write, if_id_write, id_ex_bubble, ex_mem_hold,
           if_id_flush, id_ex_flush, dmem_req, mem_timeout};
    for (int i = 0; i < 8; i++) chk1(onames[i], obs[7-i], exp[7-i]);
    exp_cnt = (m_stalls >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(m_stalls);
    chkn("stall_count", stall_count, exp_cnt);
    if (!r) begin
      m_freeze_len  = frz ? m_freeze_len + 1 : 0;
      if (frz && m_freeze_len >= WAIT_MAX + 1) m_timeout = 1'b1;
      if (frz || bub) m_stalls++;
      m_skip        = fl && !m_prev_freeze;
      m_prev_freeze = frz;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic slow;
    model_reset();
    reset = 1'b1; id_ex_memread = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    #1;
    chk1("rst_pc_write", pc_write, 1'b1);
    chk1("rst_timeout", mem_timeout, 1'b0);
    chkn("rst_stall_count", stall_count, 4'd0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Load-use on rs, then the same pattern against r0 which must not stall.
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("lu_pc_write", pc_write, 1'b0);
    chk1("lu_if_id_write", if_id_write, 1'b0);
    chk1("lu_bubble", id_ex_bubble, 1'b1);
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk1("lu_r0_pc_write", pc_write, 1'b1);
    chk1("lu_r0_bubble", id_ex_bubble, 1'b0);
    chkn("lu_stall_count", stall_count, 4'd1);

    // Three-cycle memory wait.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk1("mw_hold", ex_mem_hold, 1'b1);
      chk1("mw_req", dmem_req, 1'b1);
    end
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk1("mw_release_hold", ex_mem_hold, 1'b0);
    chk1("mw_release_req", dmem_req, 1'b1);
    chk1("mw_release_pc", pc_write, 1'b1);
    idle();
    chkn("mw_stall_count", stall_count, 4'd4);
    chk1("mw_after_pc", pc_write, 1'b1);

    // Ten-cycle wait: timeout visible from the 10th cycle (after the 9th edge).
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk1("to_flag", mem_timeout, (i == 10) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    chk1("to_sticky", mem_timeout, 1'b1);
    chkn("to_stall_count", stall_count, 4'd14);

    // Branch with a simultaneous load-use, then the FLUSH cycle ignores both.
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk1("br_if_id_flush", if_id_flush, 1'b1);
    chk1("br_id_ex_flush", id_ex_flush, 1'b1);
    chk1("br_bubble", id_ex_bubble, 1'b0);
    chk1("br_pc_write", pc_write, 1'b1);
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk1("fl_if_id_flush", if_id_flush, 1'b0);
    chk1("fl_id_ex_flush", id_ex_flush, 1'b0);
    chk1("fl_bubble", id_ex_bubble, 1'b0);
    idle();

    // Branch held during a freeze; stall counter saturates at 15 along the way.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk1("pri_no_flush", if_id_flush, 1'b0);
    end
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk1("pri_release_flush", if_id_flush, 1'b1);
    chk1("pri_release_hold", ex_mem_hold, 1'b0);
    idle();
    chkn("sat_stall_count", stall_count, 4'd15);

    // Reset pulse in the middle of a wait acts before the next clock edge.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_mem_memread = 1'b0;
    reset = 1'b1;
    #1;
    chk1("arst_pc_write", pc_write, 1'b1);
    chk1("arst_hold", ex_mem_hold, 1'b0);
    chk1("arst_timeout", mem_timeout, 1'b0);
    chkn("arst_stall_count", stall_count, 4'd0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Randomized traffic, with slow-memory phases to reach the timeout.
    slow = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) slow = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 249) == 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
           slow ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
